instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//   Program-counter and next-PC stage feeding riscv_cpu's 7-bit instruction address.
//   Holds the PC register, selects the next PC (PC+4 or branch target) and supports stall.
//   Stops fetching on a fatal fetch condition (misaligned target or address wrap).
//   Consumes branch/zero/immediate from the datapath of the same cycle.
// PARAMETERS
//   ADDR_WIDTH  7   width of PC / instruction address, in bytes
//   IMM_WIDTH   64  width of immediate generator output
//   RESET_PC    0   PC value loaded on reset; must be a multiple of 4
// PORTS
//   clk            in   1           rising-edge clock
//   reset          in   1           synchronous, active-high reset
//   stall          in   1           1 = hold PC this cycle
//   branch         in   1           control unit branch flag for current instruction
//   zero           in   1           ALU zero flag for current instruction
//   imm            in   IMM_WIDTH   immediate for current instruction (halfword offset)
//   address        out  ADDR_WIDTH  current PC, drives instruction memory / riscv_cpu
//   pc_valid       out  1           1 = address holds a fetchable instruction
//   halted         out  1           1 = fetch stopped; sticky until reset
//   misaligned     out  1           1 = halt caused by target with addr[1:0]!=0; sticky
// BEHAVIOUR
//   - Reset (sampled at posedge clk when reset=1), wins over all other inputs:
//     address=RESET_PC, pc_valid=0, halted=0, misaligned=0, state=BOOT.
//     A reset asserted mid-operation or while HALTED behaves the same way.
//   - FSM states:
//     BOOT -> RUN after one cycle; pc_valid=1 from the RUN cycle on. Gives instruction memory one settle cycle.
//     RUN: at each posedge with stall=0:
//       taken  = branch & zero
//       target = address + (imm << 1), low ADDR_WIDTH bits only; imm is two's complement, upper bits dropped.
//       seq    = address + 4, computed ADDR_WIDTH+1 wide.
//       If taken and target[1:0]!=0: address holds, misaligned=1, halted=1, pc_valid=0, state=HALT.
//       Else if taken: address=target. Backward and forward targets both allowed; the sum wraps mod 2^ADDR_WIDTH.
//       Else if seq carries out of ADDR_WIDTH (PC is last word): address holds, halted=1, pc_valid=0, state=HALT.
//       Else: address=seq.
//     RUN with stall=1: address, pc_valid and state hold. branch, zero and imm are ignored that cycle.
//     HALT: all outputs hold; exits only by reset.
//   - Latency: new address is visible one cycle after the posedge that samples branch/zero/imm.
//   - Inputs refer to the instruction at the current address. The unit has no buffering or prediction.
//   - stall is ignored in BOOT and HALT.
//   - RESET_PC not a multiple of 4: compile-time error ($error in an initial/generate check).
// CONFIGURATION
//   FETCH_PERF_COUNTERS_EN: when defined, adds two ports:
//     fetch_count   out 32  +1 per RUN cycle with stall=0 that does not enter HALT
//     taken_count   out 32  +1 per successful taken branch
//   Both are 0 on reset, wrap modulo 2^32 and hold in HALT.
//   When not defined: these ports and their registers do not exist. All other behaviour is identical.
// TESTING
//   1. Reset, then 4 cycles with stall=0, branch=0 -> address 0 (BOOT), 0, 4, 8, 12; pc_valid 0,1,1,1,1.
//   2. At address=8: branch=1, zero=1, imm=-4 -> next address=0. With zero=0 -> next address=12.
//   3. At address=16: stall=1 for 3 cycles with branch=1, zero=1, imm=8 -> address stays 16. Then stall=0, branch=0 -> 20.
//   4. At address=4: taken branch with imm=1 (target 6) -> halted=1, misaligned=1, pc_valid=0, address=4.
//      Then 5 more cycles -> no change.
//   5. Run sequentially to address=124 (ADDR_WIDTH=7) -> next cycle halted=1, misaligned=0, address=124.
//      Then reset -> address=0, halted=0.
//   6. FETCH_PERF_COUNTERS_EN defined: run scenario 1 plus one taken branch -> fetch_count=4, taken_count=1.
//      Mid-run reset clears both to 0.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bundle: datapath/control inputs toward the PC stage and PC-side status outputs.
// Counter signals exist only when FETCH_PERF_COUNTERS_EN is defined.
interface instruction_fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned IMM_WIDTH  = 64
);
  logic                  stall;
  logic                  branch;
  logic                  zero;
  logic [IMM_WIDTH-1:0]  imm;
  logic [ADDR_WIDTH-1:0] address;
  logic                  pc_valid;
  logic                  halted;
  logic                  misaligned;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0]           fetch_count;
  logic [31:0]           taken_count;

  modport master (
    output stall, branch, zero, imm,
    input  address, pc_valid, halted, misaligned, fetch_count, taken_count
  );
  modport slave (
    input  stall, branch, zero, imm,
    output address, pc_valid, halted, misaligned, fetch_count, taken_count
  );
`else
  modport master (
    output stall, branch, zero, imm,
    input  address, pc_valid, halted, misaligned
  );
  modport slave (
    input  stall, branch, zero, imm,
    output address, pc_valid, halted, misaligned
  );
`endif
endinterface

// File: rtl/instruction_fetch_unit.sv
// PC register and next-PC selection (PC+4 / branch target) with stall and sticky fatal halt.
// Optional fetch/taken counters are built when FETCH_PERF_COUNTERS_EN is defined.
module instruction_fetch_unit #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned IMM_WIDTH  = 64,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  instruction_fetch_unit_if.slave bus
);
  localparam int unsigned SEQ_WIDTH = ADDR_WIDTH + 1;

  if ((RESET_PC % 4) != 0) begin : g_reset_pc_check
    $error("RESET_PC must be a multiple of 4");
  end

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] address_q;
  logic                  pc_valid_q;
  logic                  halted_q;
  logic                  misaligned_q;
  logic                  taken_d;
  logic [ADDR_WIDTH-1:0] target_d;
  logic [SEQ_WIDTH-1:0]  seq_d;
  logic                  imm_unused;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0]           fetch_count_q;
  logic [31:0]           taken_count_q;
`endif

  // Offset is in halfwords; only the bits that reach the PC width matter, so the sum wraps.
  always_comb begin
    taken_d  = bus.branch & bus.zero;
    target_d = address_q + ADDR_WIDTH'({bus.imm[ADDR_WIDTH-2:0], 1'b0});
    seq_d    = SEQ_WIDTH'(address_q) + SEQ_WIDTH'(4);
  end

  assign imm_unused = ^bus.imm[IMM_WIDTH-1:ADDR_WIDTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_BOOT;
      address_q     <= ADDR_WIDTH'(RESET_PC);
      pc_valid_q    <= 1'b0;
      halted_q      <= 1'b0;
      misaligned_q  <= 1'b0;
`ifdef FETCH_PERF_COUNTERS_EN
      fetch_count_q <= 32'd0;
      taken_count_q <= 32'd0;
`endif
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_q    <= ST_RUN;
          pc_valid_q <= 1'b1;
        end
        ST_RUN: begin
          if (!bus.stall) begin
            if (taken_d && (target_d[1:0] != 2'b00)) begin
              misaligned_q <= 1'b1;
              halted_q     <= 1'b1;
              pc_valid_q   <= 1'b0;
              state_q      <= ST_HALT;
            end else if (taken_d) begin
              address_q     <= target_d;
`ifdef FETCH_PERF_COUNTERS_EN
              fetch_count_q <= fetch_count_q + 32'd1;
              taken_count_q <= taken_count_q + 32'd1;
`endif
            end else if (seq_d[ADDR_WIDTH]) begin
              // Last word of the address space: nothing left to fetch.
              halted_q   <= 1'b1;
              pc_valid_q <= 1'b0;
              state_q    <= ST_HALT;
            end else begin
              address_q     <= seq_d[ADDR_WIDTH-1:0];
`ifdef FETCH_PERF_COUNTERS_EN
              fetch_count_q <= fetch_count_q + 32'd1;
`endif
            end
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign bus.address    = address_q;
  assign bus.pc_valid   = pc_valid_q;
  assign bus.halted     = halted_q;
  assign bus.misaligned = misaligned_q;
`ifdef FETCH_PERF_COUNTERS_EN
  assign bus.fetch_count = fetch_count_q;
  assign bus.taken_count = taken_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized traffic against a PC-level model.
module tb_instruction_fetch_unit;
  localparam int unsigned ADDR_WIDTH = 7;
  localparam int unsigned IMM_WIDTH  = 64;
  localparam int unsigned RESET_PC   = 0;
  localparam int unsigned PC_SPAN    = 1 << ADDR_WIDTH;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  instruction_fetch_unit_if #(.ADDR_WIDTH(ADDR_WIDTH), .IMM_WIDTH(IMM_WIDTH)) bus ();

  instruction_fetch_unit #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .IMM_WIDTH (IMM_WIDTH),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: PC as a plain integer, phase flags, event counts.
  int unsigned m_pc;
  bit          m_boot;
  bit          m_halt;
  bit          m_mis;
  int unsigned m_fetch;
  int unsigned m_taken;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit stall, input bit br, input bit z,
                            input logic [63:0] imm);
    longint unsigned t;
    if (rst) begin
      m_pc = RESET_PC; m_boot = 1'b1; m_halt = 1'b0; m_mis = 1'b0;
      m_fetch = 0; m_taken = 0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_halt && !stall) begin
      if (br && z) begin
        t = (64'(m_pc) + (imm << 1)) % 64'(PC_SPAN);
        if ((t % 4) != 0) begin
          m_halt = 1'b1;
          m_mis  = 1'b1;
        end else begin
          m_pc = 32'(t);
          m_taken++;
          m_fetch++;
        end
      end else if (m_pc + 4 >= PC_SPAN) begin
        m_halt = 1'b1;
      end else begin
        m_pc += 4;
        m_fetch++;
      end
    end
  endtask

  task automatic step(input bit rst, input bit stall, input bit br, input bit z,
                      input logic [63:0] imm);
    reset      = rst;
    bus.stall  = stall;
    bus.branch = br;
    bus.zero   = z;
    bus.imm    = imm;
    model_step(rst, stall, br, z, imm);
    @(posedge clk);
    #1;
    check("address",    64'(bus.address),    64'(m_pc));
    check("pc_valid",   64'(bus.pc_valid),   64'(!m_boot && !m_halt));
    check("halted",     64'(bus.halted),     64'(m_halt));
    check("misaligned", 64'(bus.misaligned), 64'(m_mis));
`ifdef FETCH_PERF_COUNTERS_EN
    check("fetch_count", 64'(bus.fetch_count), 64'(m_fetch));
    check("taken_count", 64'(bus.taken_count), 64'(m_taken));
`endif
  endtask

  // Reset, leave BOOT, then walk sequentially up to the requested address.
  task automatic goto_pc(input int unsigned addr);
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    for (int i = 0; i < int'(addr / 4); i++) step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
  endtask

  initial begin
    int          k;
    longint      li;
    logic [63:0] rimm;
    bit          rrst, rstall, rbr, rz;

    reset = 1'b1; bus.stall = 1'b0; bus.branch = 1'b0; bus.zero = 1'b0; bus.imm = '0;

    // Reset and sequential fetch
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
    check("s1_boot_addr",  64'(bus.address),  64'd0);
    check("s1_boot_valid", 64'(bus.pc_valid), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    check("s1_addr", 64'(bus.address), 64'd12);

    // Backward taken branch, then same branch not taken
    goto_pc(8);
    step(1'b0, 1'b0, 1'b1, 1'b1, -64'sd4);
    check("s2_taken", 64'(bus.address), 64'd0);
    goto_pc(8);
    step(1'b0, 1'b0, 1'b1, 1'b0, -64'sd4);
    check("s2_not_taken", 64'(bus.address), 64'd12);

    // Stall masks a taken branch
    goto_pc(16);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 64'd8);
    check("s3_stalled", 64'(bus.address), 64'd16);
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    check("s3_resume", 64'(bus.address), 64'd20);

    // Misaligned target halts and sticks
    goto_pc(4);
    step(1'b0, 1'b0, 1'b1, 1'b1, 64'd1);
    check("s4_halted", 64'(bus.halted), 64'd1);
    check("s4_mis",    64'(bus.misaligned), 64'd1);
    check("s4_valid",  64'(bus.pc_valid), 64'd0);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), {$urandom, $urandom});
    check("s4_hold_addr", 64'(bus.address), 64'd4);

    // End of address space halts without misaligned
    goto_pc(124);
    check("s5_at_end", 64'(bus.address), 64'd124);
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    check("s5_halted", 64'(bus.halted), 64'd1);
    check("s5_mis",    64'(bus.misaligned), 64'd0);
    check("s5_addr",   64'(bus.address), 64'd124);
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
    check("s5_reset_addr",   64'(bus.address), 64'd0);
    check("s5_reset_halted", 64'(bus.halted), 64'd0);

`ifdef FETCH_PERF_COUNTERS_EN
    goto_pc(12);
    step(1'b0, 1'b0, 1'b1, 1'b1, 64'd2);
    check("s6_fetch", 64'(bus.fetch_count), 64'd4);
    check("s6_taken", 64'(bus.taken_count), 64'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
    check("s6_fetch_rst", 64'(bus.fetch_count), 64'd0);
    check("s6_taken_rst", 64'(bus.taken_count), 64'd0);
`endif

    // Randomized traffic with occasional resets
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
    for (int n = 0; n < 3000; n++) begin
      rrst   = ($urandom_range(0, 99) < 2);
      rstall = ($urandom_range(0, 99) < 25);
      rbr    = 1'($urandom);
      rz     = 1'($urandom);
      k      = $urandom_range(0, 99);
      if (k < 70) begin
        li   = 2 * ($signed($urandom_range(0, 40)) - 20);
        rimm = li;
      end else if (k < 85) begin
        li   = 2 * ($signed($urandom_range(0, 40)) - 20) + 1;
        rimm = li;
      end else begin
        rimm = {$urandom, $urandom};
      end
      step(rrst, rstall, rbr, rz, rimm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
